// File: rtl/partition_pkg.sv
// Shared constants for the partition engine: opcodes, response status codes,
// controller states and mu-ledger cost constants.
package partition_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_PNEW      = 3'd1;
  localparam logic [2:0] OP_PSPLIT    = 3'd2;
  localparam logic [2:0] OP_PMERGE    = 3'd3;
  localparam logic [2:0] OP_PDISCOVER = 3'd4;
  localparam logic [2:0] OP_PREAD     = 3'd5;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_BAD_ID  = 2'd2;
  localparam logic [1:0] ST_OVERLAP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SCAN = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int MU_MERGE_COST        = 4;
  localparam int MU_DISCOVER_PER_MOD  = 8;

  // A split is charged one unit per region bit.
  function automatic int mu_split_cost(input int region_width);
    return region_width;
  endfunction

endpackage

// File: rtl/part_popcount.sv
// Combinational population count of a parametrised-width vector.
module part_popcount #(
  parameter int W  = 64,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/partition_engine.sv
// Partition engine: slot table of region masks with a saturating mu ledger.
// Optional build macro PARTITION_ENGINE_OVERLAP_CHECK_EN rejects overlapping PNEW.
module partition_engine
  import partition_pkg::*;
#(
  parameter int  MAX_MODULES  = 16,
  parameter int  REGION_WIDTH = 64,
  parameter int  MU_WIDTH     = 32,
  localparam int ID_W         = $clog2(MAX_MODULES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [REGION_WIDTH-1:0] req_region,
  input  logic [ID_W-1:0]         req_id_a,
  input  logic [ID_W-1:0]         req_id_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_status,
  output logic [ID_W-1:0]         rsp_id,
  output logic [REGION_WIDTH-1:0] rsp_region,
  output logic [MAX_MODULES-1:0]  valid_mask,
  output logic [ID_W:0]           num_modules,
  output logic [MU_WIDTH-1:0]     mu_total,
  output logic                    busy
);

  localparam int SLOTS_P2 = 1 << ID_W;
  localparam int CNT_W    = ID_W + 1;
  localparam int PC_W     = $clog2(REGION_WIDTH + 1);
  localparam int SUM_W    = ((MU_WIDTH > 32) ? MU_WIDTH : 32) + 1;
  localparam logic [SUM_W-1:0] MU_MAX = SUM_W'({MU_WIDTH{1'b1}});

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [REGION_WIDTH-1:0] region_q, region_d;
  logic [ID_W-1:0]         id_a_q, id_a_d, id_b_q, id_b_d;
  logic [REGION_WIDTH-1:0] slots_q [SLOTS_P2];
  logic [REGION_WIDTH-1:0] slots_d [SLOTS_P2];
  logic [SLOTS_P2-1:0]     valid_q, valid_d;
  logic [MU_WIDTH-1:0]     mu_q, mu_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [REGION_WIDTH-1:0] rsp_region_q, rsp_region_d;
  logic [ID_W-1:0]         scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]        scan_cnt_q, scan_cnt_d;

  logic                    has_free;
  logic [ID_W-1:0]         free_idx;
  logic                    pnew_overlap;
  logic [PC_W-1:0]         pnew_cost;
  logic [CNT_W-1:0]        scan_cnt_nx;
  logic [REGION_WIDTH-1:0] merged;

  // Saturating ledger add: the ledger sticks at all-ones instead of wrapping.
  function automatic logic [MU_WIDTH-1:0] sat_add(input logic [MU_WIDTH-1:0] a,
                                                  input logic [31:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > MU_MAX) ? {MU_WIDTH{1'b1}} : MU_WIDTH'(s);
  endfunction

  part_popcount #(.W(REGION_WIDTH), .CW(PC_W)) u_cost_pc (
    .vec   (region_q),
    .count (pnew_cost)
  );

  part_popcount #(.W(MAX_MODULES), .CW(CNT_W)) u_valid_pc (
    .vec   (valid_q[MAX_MODULES-1:0]),
    .count (num_modules)
  );

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = MAX_MODULES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = ID_W'(i);
      end
    end
  end

`ifdef PARTITION_ENGINE_OVERLAP_CHECK_EN
  always_comb begin
    pnew_overlap = 1'b0;
    for (int i = 0; i < MAX_MODULES; i++) begin
      if (valid_q[i] && (|(slots_q[i] & region_q))) pnew_overlap = 1'b1;
    end
  end
`else
  assign pnew_overlap = 1'b0;
`endif

  assign scan_cnt_nx = scan_cnt_q +
                       CNT_W'(valid_q[scan_idx_q] && (|slots_q[scan_idx_q]));
  assign merged      = slots_q[id_a_q] | slots_q[id_b_q];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    region_d     = region_q;
    id_a_d       = id_a_q;
    id_b_d       = id_b_q;
    slots_d      = slots_q;
    valid_d      = valid_q;
    mu_d         = mu_q;
    rsp_status_d = rsp_status_q;
    rsp_id_d     = rsp_id_q;
    rsp_region_d = rsp_region_q;
    scan_idx_d   = scan_idx_q;
    scan_cnt_d   = scan_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          region_d = req_region;
          id_a_d   = req_id_a;
          id_b_d   = req_id_b;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d      = S_RESP;
        rsp_status_d = ST_OK;
        rsp_id_d     = '0;
        rsp_region_d = '0;
        case (op_q)
          OP_PNEW: begin
            if (pnew_overlap)  rsp_status_d = ST_OVERLAP;
            else if (!has_free) rsp_status_d = ST_FULL;
            else begin
              slots_d[free_idx] = region_q;
              valid_d[free_idx] = 1'b1;
              rsp_id_d          = free_idx;
              rsp_region_d      = region_q;
              mu_d              = sat_add(mu_q, 32'(pnew_cost));
            end
          end
          OP_PSPLIT: begin
            if (!valid_q[id_a_q]) rsp_status_d = ST_BAD_ID;
            else if (!has_free)   rsp_status_d = ST_FULL;
            else begin
              slots_d[id_a_q]   = slots_q[id_a_q] & ~region_q;
              slots_d[free_idx] = slots_q[id_a_q] & region_q;
              valid_d[free_idx] = 1'b1;
              rsp_id_d          = free_idx;
              rsp_region_d      = slots_q[id_a_q] & region_q;
              mu_d              = sat_add(mu_q, 32'(mu_split_cost(REGION_WIDTH)));
            end
          end
          OP_PMERGE: begin
            if ((id_a_q == id_b_q) || !valid_q[id_a_q] || !valid_q[id_b_q]) begin
              rsp_status_d = ST_BAD_ID;
            end else begin
              slots_d[id_a_q] = merged;
              slots_d[id_b_q] = '0;
              valid_d[id_b_q] = 1'b0;
              rsp_id_d        = id_a_q;
              rsp_region_d    = merged;
              mu_d            = sat_add(mu_q, 32'(MU_MERGE_COST));
            end
          end
          OP_PDISCOVER: begin
            state_d    = S_SCAN;
            scan_idx_d = '0;
            scan_cnt_d = '0;
          end
          OP_PREAD: begin
            if (!valid_q[id_a_q]) rsp_status_d = ST_BAD_ID;
            else begin
              rsp_id_d     = id_a_q;
              rsp_region_d = slots_q[id_a_q];
            end
          end
          default: ;
        endcase
      end
      S_SCAN: begin
        scan_cnt_d = scan_cnt_nx;
        scan_idx_d = scan_idx_q + 1'b1;
        // The ledger and response commit together on the final scanned slot.
        if (scan_idx_q == ID_W'(MAX_MODULES - 1)) begin
          state_d      = S_RESP;
          rsp_status_d = ST_OK;
          rsp_id_d     = scan_cnt_nx[ID_W-1:0];
          rsp_region_d = REGION_WIDTH'(scan_cnt_nx >= CNT_W'(2));
          mu_d         = sat_add(mu_q, 32'(scan_cnt_nx) * 32'(MU_DISCOVER_PER_MOD));
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      region_q     <= '0;
      id_a_q       <= '0;
      id_b_q       <= '0;
      for (int i = 0; i < SLOTS_P2; i++) slots_q[i] <= '0;
      valid_q      <= '0;
      mu_q         <= '0;
      rsp_status_q <= ST_OK;
      rsp_id_q     <= '0;
      rsp_region_q <= '0;
      scan_idx_q   <= '0;
      scan_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      region_q     <= region_d;
      id_a_q       <= id_a_d;
      id_b_q       <= id_b_d;
      slots_q      <= slots_d;
      valid_q      <= valid_d;
      mu_q         <= mu_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
      rsp_region_q <= rsp_region_d;
      scan_idx_q   <= scan_idx_d;
      scan_cnt_q   <= scan_cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_status = rsp_status_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_region = rsp_region_q;
  assign valid_mask = valid_q[MAX_MODULES-1:0];
  assign mu_total   = mu_q;

endmodule

// File: tb/tb_partition_engine.sv
// Scoreboard bench for partition_engine: a reference slot/ledger model pushes
// expected responses at request time; scenario tasks pop and compare them.
module tb_partition_engine;

  localparam int MAXM = 16;
  localparam int RW   = 64;
  localparam int MUW  = 10;
  localparam longint MU_MAX = (64'd1 << MUW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [RW-1:0] req_region = '0;
  logic [3:0]    req_id_a = '0;
  logic [3:0]    req_id_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_status;
  logic [3:0]    rsp_id;
  logic [RW-1:0] rsp_region;
  logic [MAXM-1:0] valid_mask;
  logic [4:0]    num_modules;
  logic [MUW-1:0] mu_total;
  logic          busy;

  partition_engine #(.MAX_MODULES(MAXM), .REGION_WIDTH(RW), .MU_WIDTH(MUW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_region(req_region), .req_id_a(req_id_a), .req_id_b(req_id_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_id(rsp_id), .rsp_region(rsp_region), .valid_mask(valid_mask),
    .num_modules(num_modules), .mu_total(mu_total), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    st;
    logic [3:0]    id;
    logic [RW-1:0] rg;
  } rsp_t;

  rsp_t          sb[$];
  logic [RW-1:0] m_slot [MAXM];
  bit            m_valid [MAXM];
  longint        m_mu;
  int            n_tests = 0;
  int            n_fail = 0;

  function automatic void model_reset();
    for (int i = 0; i < MAXM; i++) begin
      m_slot[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_mu = 0;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < MAXM; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [MAXM-1:0] m_mask();
    logic [MAXM-1:0] m;
    for (int i = 0; i < MAXM; i++) m[i] = m_valid[i];
    return m;
  endfunction

  function automatic void m_charge(input longint c);
    m_mu = (m_mu + c > MU_MAX) ? MU_MAX : m_mu + c;
  endfunction

  function automatic void model_push(input logic [2:0] op, input logic [RW-1:0] rg,
                                     input int a, input int b);
    rsp_t e;
    int   f;
    int   cnt;
    bit   ovl;
    e.st = 2'd0; e.id = 4'd0; e.rg = '0;
    f = m_free();
    case (op)
      3'd1: begin
        ovl = 1'b0;
`ifdef PARTITION_ENGINE_OVERLAP_CHECK_EN
        for (int i = 0; i < MAXM; i++) if (m_valid[i] && ((m_slot[i] & rg) != 0)) ovl = 1'b1;
`endif
        if (ovl) e.st = 2'd3;
        else if (f < 0) e.st = 2'd1;
        else begin
          m_slot[f] = rg; m_valid[f] = 1'b1;
          e.id = 4'(f); e.rg = rg;
          m_charge($countones(rg));
        end
      end
      3'd2: begin
        if (!m_valid[a]) e.st = 2'd2;
        else if (f < 0) e.st = 2'd1;
        else begin
          m_slot[f] = m_slot[a] & rg; m_valid[f] = 1'b1;
          m_slot[a] = m_slot[a] & ~rg;
          e.id = 4'(f); e.rg = m_slot[f];
          m_charge(RW);
        end
      end
      3'd3: begin
        if (a == b || !m_valid[a] || !m_valid[b]) e.st = 2'd2;
        else begin
          m_slot[a] = m_slot[a] | m_slot[b];
          m_slot[b] = '0; m_valid[b] = 1'b0;
          e.id = 4'(a); e.rg = m_slot[a];
          m_charge(4);
        end
      end
      3'd4: begin
        cnt = 0;
        for (int i = 0; i < MAXM; i++) if (m_valid[i] && m_slot[i] != 0) cnt++;
        e.id = 4'(cnt); e.rg = (cnt >= 2) ? RW'(1) : RW'(0);
        m_charge(8 * cnt);
      end
      3'd5: begin
        if (!m_valid[a]) e.st = 2'd2;
        else begin e.id = 4'(a); e.rg = m_slot[a]; end
      end
      default: ;
    endcase
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_req(input logic [2:0] op, input logic [RW-1:0] rg,
                          input int a, input int b);
    model_push(op, rg, a, b);
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_op = op; req_region = rg;
    req_id_a = 4'(a); req_id_b = 4'(b);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'd0; req_region = '0;
  endtask

  task automatic wait_rsp(output rsp_t obs, output rsp_t exp, output int lat);
    obs.st = 'x; obs.id = 'x; obs.rg = 'x;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        obs.st = rsp_status; obs.id = rsp_id; obs.rg = rsp_region;
        break;
      end
    end
    exp = sb.pop_front();
    if (rsp_valid && rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [RW-1:0] rg, input int a,
                        input int b, output rsp_t obs, output rsp_t exp, output int lat);
    send_req(op, rg, a, b);
    wait_rsp(obs, exp, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, busy} !== 3'b000 && {rsp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_held: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, busy, valid_mask, num_modules, mu_total} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rsp_valid=%b busy=%b mask=%h num=%0d mu=%0d, required 1 0 0 0 0 0",
               req_ready, rsp_valid, busy, valid_mask, num_modules, mu_total);
    end
  endtask

  task automatic test_pnew_basic();
    rsp_t o, e;
    int   lat;
    do_reset();
    run_op(3'd1, 64'hF0, 0, 0, o, e, lat);
    n_tests++;
    if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || e.id !== 4'd0 || e.st !== 2'd0) begin
      n_fail++;
      $display("FAIL pnew_basic_rsp: got st=%0d id=%0d rg=%h, required st=%0d id=%0d rg=%h",
               o.st, o.id, o.rg, e.st, e.id, e.rg);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL pnew_latency: got %0d cycles, required 2", lat);
    end
    n_tests++;
    if (mu_total !== 10'd4 || num_modules !== 5'd1 || valid_mask !== m_mask()) begin
      n_fail++;
      $display("FAIL pnew_state: mu=%0d num=%0d mask=%h, required mu=4 num=1 mask=%h",
               mu_total, num_modules, valid_mask, m_mask());
    end
  endtask

  task automatic test_fill();
    rsp_t o, e;
    int   lat;
    do_reset();
    for (int i = 0; i < MAXM; i++) begin
      run_op(3'd1, 64'h1 << i, 0, 0, o, e, lat);
      n_tests++;
      if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || o.id !== 4'(i)) begin
        n_fail++;
        $display("FAIL fill_%0d: got st=%0d id=%0d rg=%h, required st=%0d id=%0d rg=%h",
                 i, o.st, o.id, o.rg, e.st, e.id, e.rg);
      end
    end
    run_op(3'd1, 64'hFFFF_0000, 0, 0, o, e, lat);
    n_tests++;
    if (o.st !== 2'd1 || o.st !== e.st) begin
      n_fail++;
      $display("FAIL fill_full: got st=%0d, required st=%0d", o.st, e.st);
    end
    n_tests++;
    if (mu_total !== MUW'(m_mu) || mu_total !== 10'd16 || num_modules !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_full_state: mu=%0d num=%0d, required mu=16 num=16", mu_total, num_modules);
    end
  endtask

  task automatic test_split_merge();
    rsp_t o, e;
    int   lat;
    logic [2:0] ops [8] = '{3'd1, 3'd2, 3'd5, 3'd5, 3'd3, 3'd3, 3'd5, 3'd2};
    logic [RW-1:0] rgs [8] = '{64'hFF, 64'h0F, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h3};
    int   as [8] = '{0, 0, 0, 1, 0, 0, 1, 5};
    int   bs [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], rgs[i], as[i], bs[i], o, e, lat);
      n_tests++;
      if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || lat !== 2) begin
        n_fail++;
        $display("FAIL split_merge_%0d: got st=%0d id=%0d rg=%h lat=%0d, required st=%0d id=%0d rg=%h lat=2",
                 i, o.st, o.id, o.rg, lat, e.st, e.id, e.rg);
      end
      n_tests++;
      if (mu_total !== MUW'(m_mu) || valid_mask !== m_mask()) begin
        n_fail++;
        $display("FAIL split_merge_state_%0d: mu=%0d mask=%h, required mu=%0d mask=%h",
                 i, mu_total, valid_mask, m_mu, m_mask());
      end
    end
    n_tests++;
    if (mu_total !== 10'd76) begin
      n_fail++;
      $display("FAIL split_merge_mu_total: got %0d, required 76", mu_total);
    end
  endtask

  task automatic test_discover();
    rsp_t o, e;
    int   lat;
    do_reset();
    run_op(3'd1, 64'h1, 0, 0, o, e, lat);
    run_op(3'd1, 64'h0, 0, 0, o, e, lat);
    n_tests++;
    if (o.st !== 2'd0 || o.id !== 4'd1 || mu_total !== 10'd1) begin
      n_fail++;
      $display("FAIL pnew_empty: got st=%0d id=%0d mu=%0d, required st=0 id=1 mu=1", o.st, o.id, mu_total);
    end
    run_op(3'd1, 64'h6, 0, 0, o, e, lat);
    run_op(3'd4, 64'h0, 0, 0, o, e, lat);
    n_tests++;
    if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || o.id !== 4'd2 || o.rg[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL discover_rsp: got st=%0d id=%0d rg=%h, required st=%0d id=%0d rg=%h",
               o.st, o.id, o.rg, e.st, e.id, e.rg);
    end
    n_tests++;
    if (lat !== MAXM + 2) begin
      n_fail++;
      $display("FAIL discover_latency: got %0d cycles, required %0d", lat, MAXM + 2);
    end
    n_tests++;
    if (mu_total !== MUW'(m_mu) || mu_total !== 10'd19) begin
      n_fail++;
      $display("FAIL discover_mu: got %0d, required 19", mu_total);
    end
  endtask

  task automatic test_overlap();
    rsp_t o, e;
    int   lat;
    do_reset();
    run_op(3'd1, 64'h3, 0, 0, o, e, lat);
    run_op(3'd1, 64'h6, 0, 0, o, e, lat);
    n_tests++;
    if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || valid_mask !== m_mask() ||
        mu_total !== MUW'(m_mu)) begin
      n_fail++;
      $display("FAIL overlap_pnew: got st=%0d id=%0d mask=%h mu=%0d, required st=%0d id=%0d mask=%h mu=%0d",
               o.st, o.id, valid_mask, mu_total, e.st, e.id, m_mask(), m_mu);
    end
  endtask

  task automatic test_backpressure();
    rsp_t o, e;
    int   lat;
    do_reset();
    run_op(3'd1, 64'h5, 0, 0, o, e, lat);
    rsp_ready = 1'b0;
    run_op(3'd5, 64'h0, 0, 0, o, e, lat);
    n_tests++;
    if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg}) begin
      n_fail++;
      $display("FAIL stall_first: got st=%0d id=%0d rg=%h, required st=%0d id=%0d rg=%h",
               o.st, o.id, o.rg, e.st, e.id, e.rg);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, req_ready, rsp_status, rsp_id, rsp_region} !== {1'b1, 1'b0, e.st, e.id, e.rg}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: valid=%b ready=%b st=%0d id=%0d rg=%h, required 1 0 %0d %0d %h",
                 i, rsp_valid, req_ready, rsp_status, rsp_id, rsp_region, e.st, e.id, e.rg);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: busy=%b ready=%b, required 0 1", busy, req_ready);
    end
  endtask

  task automatic test_saturation();
    rsp_t o, e;
    int   lat;
    do_reset();
    run_op(3'd1, {RW{1'b1}}, 0, 0, o, e, lat);
    for (int i = 0; i < 16; i++) begin
      run_op(3'd2, 64'hFF, 0, 0, o, e, lat);
      run_op(3'd3, 64'h0, 0, 1, o, e, lat);
      n_tests++;
      if (mu_total !== MUW'(m_mu) || o.st !== e.st) begin
        n_fail++;
        $display("FAIL sat_step_%0d: mu=%0d st=%0d, required mu=%0d st=%0d", i, mu_total, o.st, m_mu, e.st);
      end
    end
    n_tests++;
    if (mu_total !== {MUW{1'b1}}) begin
      n_fail++;
      $display("FAIL sat_final: got %0d, required %0d", mu_total, MU_MAX);
    end
  endtask

  task automatic test_reset_mid_op();
    rsp_t o, e;
    int   lat;
    bit   seen;
    do_reset();
    run_op(3'd1, 64'h1, 0, 0, o, e, lat);
    run_op(3'd1, 64'h2, 0, 0, o, e, lat);
    send_req(3'd4, 64'h0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, rsp_valid, valid_mask, mu_total} !== {1'b0, 1'b0, 16'h0, 10'd0}) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b valid=%b mask=%h mu=%0d, required 0 0 0 0",
               busy, rsp_valid, valid_mask, mu_total);
    end
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_rsp: rsp seen=%b ready=%b, required 0 1", seen, req_ready);
    end
    run_op(3'd0, 64'h0, 0, 0, o, e, lat);
    n_tests++;
    if ({o.st, o.id, o.rg} !== {e.st, e.id, e.rg} || lat !== 2 || mu_total !== 10'd0) begin
      n_fail++;
      $display("FAIL nop_after_abort: got st=%0d lat=%0d mu=%0d, required st=0 lat=2 mu=0", o.st, lat, mu_total);
    end
  endtask

  initial begin
    test_reset();
    test_pnew_basic();
    test_fill();
    test_split_merge();
    test_discover();
    test_overlap();
    test_backpressure();
    test_saturation();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/partition_engine.md
PARTITION_ENGINE -- requirements
Module: partition_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): MAX_MODULES, 16, module slot count (2..64).
REQ-002 SHALL have parameter REGION_WIDTH, 64, bits per region mask.
REQ-003 SHALL have parameter MU_WIDTH, 32, μ-ledger width.
REQ-004 SHALL derive localparam ID_W = $clog2(MAX_MODULES).
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, clock.
REQ-006 SHALL have port rst_n, in, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid/req_ready, in/out, 1 each, request handshake.
REQ-008 SHALL have port req_op, in, 3, opcode: 0 NOP, 1 PNEW, 2 PSPLIT, 3 PMERGE, 4 PDISCOVER, 5 PREAD.
REQ-009 SHALL have port req_region, in, REGION_WIDTH, PNEW region / PSPLIT mask.
REQ-010 SHALL have ports req_id_a/req_id_b, in, ID_W each, operand slot ids.
REQ-011 SHALL have port rsp_valid/rsp_ready, out/in, 1 each, response handshake.
REQ-012 SHALL have port rsp_status, out, 2, 0 OK, 1 FULL, 2 BAD_ID, 3 OVERLAP.
REQ-013 SHALL have ports rsp_id, out, ID_W, and rsp_region, out, REGION_WIDTH, result slot and region.
REQ-014 SHALL have ports valid_mask, out, MAX_MODULES, occupied slots; num_modules, out, ID_W+1; mu_total, out, MU_WIDTH; busy, out, 1.

Function
REQ-015 SHALL use FSM IDLE -> EXEC -> RESP -> IDLE; PDISCOVER path: EXEC -> SCAN -> RESP.
REQ-016 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready; register all req_* fields at acceptance.
REQ-017 SHALL enter RESP one cycle after EXEC for non-discover ops; rsp_valid exactly 2 cycles after acceptance.
REQ-018 SHALL hold rsp_* stable while rsp_valid && !rsp_ready; return to IDLE on rsp_ready.
REQ-019 NOP SHALL respond OK without any state or μ change.
REQ-020 PNEW SHALL write the lowest free slot, set its valid bit, return its id; FULL if no free slot; μ += popcount(region); empty region allowed at cost 0.
REQ-021 PSPLIT SHALL set slot a to region&~mask and the lowest free slot to region&mask, return new id; BAD_ID if a is invalid; FULL if no free slot; μ += REGION_WIDTH.
REQ-022 PMERGE SHALL set a to a|b, clear b region and valid bit, return a; BAD_ID if a==b or either is invalid; μ += 4.
REQ-023 PDISCOVER SHALL scan one slot per cycle for MAX_MODULES cycles, counting valid non-empty slots; rsp_region[0] = 1 (structured) if count>=2; rsp_id = count truncated to ID_W; μ += 8*count.
REQ-024 PREAD SHALL return the region of a with no μ charge; BAD_ID if a is invalid.
REQ-025 Any non-OK status SHALL leave slots, valid_mask and mu_total unchanged.
REQ-026 mu_total SHALL saturate at 2^MU_WIDTH-1; it SHALL never wrap.
REQ-027 num_modules SHALL equal popcount(valid_mask) at all times; busy = state!=IDLE.
REQ-028 Slots and mu_total SHALL update in the EXEC cycle (PDISCOVER: last SCAN cycle).

Reset
REQ-029 rst_n low SHALL asynchronously clear all slots, valid_mask, mu_total and rsp_*, and force IDLE; req_ready=1 after release.
REQ-030 Reset mid-operation SHALL abort it with no response.

Configuration
REQ-031 With PARTITION_ENGINE_OVERLAP_CHECK_EN defined, PNEW whose region intersects any valid slot SHALL return OVERLAP and change nothing.
REQ-032 Without PARTITION_ENGINE_OVERLAP_CHECK_EN, overlapping PNEW SHALL be accepted; status 3 is never produced.

Structure
REQ-033 partition_pkg SHALL hold opcode, status and FSM-state constants and the μ cost constants (SPLIT = REGION_WIDTH, MERGE 4, DISCOVER 8 per module).
REQ-034 A sub-module part_popcount (parametrised width, combinational) SHALL compute PNEW cost.

Verification
REQ-035 Reset; PNEW 0xF0 -> OK, id 0, mu_total 4, num_modules 1, rsp_valid 2 cycles after acceptance.
REQ-036 PNEW x16 -> ids 0..15 OK; 17th -> FULL, mu unchanged.
REQ-037 Slot0=0xFF, PSPLIT a=0 mask 0x0F -> slot0 0xF0, new slot 0x0F; μ += 64; PMERGE a=0 b=0 -> BAD_ID.
REQ-038 Two non-empty modules, PDISCOVER -> structured=1, rsp_id 2, μ += 16, rsp_valid MAX_MODULES+2 cycles after acceptance.
REQ-039 rsp_ready low 5 cycles -> rsp_* stable, req_ready 0; mu_total preset near max -> saturates at all-ones.
REQ-040 With OVERLAP_CHECK_EN: slot0=0x3, PNEW 0x6 -> OVERLAP; without: OK id 1.
